// File: rtl/view_control_if.sv
// ---------------------------------------------------------------------------
// view_control_if
// Bundles the frame-request handshake and the view/VGA control strobes of
// view_control.
//   start, obj_count, obj_type          : requester/object table -> controller
//   obj_index                           : controller -> object table
//   load_x, load_y, load_stone,
//   resetn_c, enable_c,
//   enable_x_adder, enable_y_adder,
//   draw_background                     : controller -> view datapath
//   plot                                : controller -> VGA write enable
//   busy, done                          : controller -> requester
// master : the side that requests frames and supplies sprite data.
// slave  : the controller itself.
// ---------------------------------------------------------------------------
interface view_control_if;
    logic       start;
    logic [3:0] obj_count;
    logic       obj_type;
    logic [2:0] obj_index;
    logic       load_x;
    logic       load_y;
    logic       load_stone;
    logic       resetn_c;
    logic       enable_c;
    logic       enable_x_adder;
    logic       enable_y_adder;
    logic       draw_background;
    logic       plot;
    logic       busy;
    logic       done;

    modport master (
        output start, obj_count, obj_type,
        input  obj_index, load_x, load_y, load_stone, resetn_c, enable_c,
               enable_x_adder, enable_y_adder, draw_background, plot,
               busy, done
    );

    modport slave (
        input  start, obj_count, obj_type,
        output obj_index, load_x, load_y, load_stone, resetn_c, enable_c,
               enable_x_adder, enable_y_adder, draw_background, plot,
               busy, done
    );
endinterface

// File: rtl/view_control.sv
// ---------------------------------------------------------------------------
// view_control
// Frame sequencer for the view datapath: a full-screen background pass
// (131072 cycles, 17-bit x/y sweep) followed by up to OBJ_MAX 16x16 sprite
// passes (256 cycles each), then a PIPE-cycle flush so in-flight pixels reach
// the VGA memory before done pulses.
// Ports:
//   clk   : single clock, all state changes on the rising edge
//   reset : asynchronous active-high clear
//   bus   : view_control_if.slave (handshake, sprite select, view strobes)
// ---------------------------------------------------------------------------
module view_control #(
    parameter int OBJ_MAX = 8,
    parameter int PIPE    = 2,
    parameter int SCR_W   = 320,
    parameter int SCR_H   = 240
) (
    input  logic               clk,
    input  logic               reset,
    view_control_if.slave      bus
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_BG, ST_OBJ_LOAD, ST_OBJ_DRAW, ST_OBJ_NEXT, ST_FLUSH, ST_DONE
    } state_t;

    localparam int          FW         = (PIPE > 1) ? $clog2(PIPE) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(PIPE - 1);
    localparam logic [16:0] BG_LAST    = 17'h1FFFF;
    localparam logic [8:0]  SCR_W_L    = 9'(SCR_W);
    localparam logic [7:0]  SCR_H_L    = 8'(SCR_H);
    localparam logic [3:0]  OBJ_MAX_L  = 4'(OBJ_MAX);

    state_t        state_reg, state_next;
    logic [16:0]   bg_cnt_reg;
    logic [7:0]    spr_cnt_reg;
    logic [FW-1:0] flush_cnt_reg;
    logic [3:0]    n_obj_reg;
    logic [2:0]    obj_index_reg;
    logic          last_obj;
    logic          plot_qual;
    logic [PIPE-1:0] plot_pipe_reg;

    logic load_x_reg, load_y_reg, load_stone_reg, resetn_c_reg;
    logic enable_reg, draw_background_reg, busy_reg, done_reg;

    assign last_obj = (({1'b0, obj_index_reg} + 4'd1) == n_obj_reg);

    // Pixel is worth writing: visible part of the background sweep, or any
    // sprite cycle. Aligned with the cycle the view sees the enables.
    assign plot_qual = ((state_reg == ST_BG) &&
                        (bg_cnt_reg[8:0] < SCR_W_L) &&
                        (bg_cnt_reg[16:9] < SCR_H_L)) ||
                       (state_reg == ST_OBJ_DRAW);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (bus.start) state_next = ST_BG;
            ST_BG:       if (bg_cnt_reg == BG_LAST)
                             state_next = (n_obj_reg == 4'd0) ? ST_FLUSH : ST_OBJ_LOAD;
            ST_OBJ_LOAD: state_next = ST_OBJ_DRAW;
            ST_OBJ_DRAW: if (spr_cnt_reg == 8'hFF) state_next = ST_OBJ_NEXT;
            ST_OBJ_NEXT: state_next = last_obj ? ST_FLUSH : ST_OBJ_LOAD;
            ST_FLUSH:    if (flush_cnt_reg == FLUSH_LAST) state_next = ST_DONE;
            ST_DONE:     state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up exactly
    // with the state they belong to, without decode glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg           <= ST_IDLE;
            bg_cnt_reg          <= '0;
            spr_cnt_reg         <= '0;
            flush_cnt_reg       <= '0;
            n_obj_reg           <= '0;
            obj_index_reg       <= '0;
            load_x_reg          <= 1'b0;
            load_y_reg          <= 1'b0;
            load_stone_reg      <= 1'b0;
            resetn_c_reg        <= 1'b0;
            enable_reg          <= 1'b0;
            draw_background_reg <= 1'b0;
            busy_reg            <= 1'b0;
            done_reg            <= 1'b0;
        end else begin
            state_reg <= state_next;

            case (state_reg)
                ST_IDLE: if (bus.start) begin
                    n_obj_reg     <= (bus.obj_count > OBJ_MAX_L) ? OBJ_MAX_L : bus.obj_count;
                    obj_index_reg <= '0;
                end
                // Runs the full 2^17 sweep, so it is back at 0 for the next frame.
                ST_BG:       bg_cnt_reg  <= bg_cnt_reg + 17'd1;
                ST_OBJ_LOAD: spr_cnt_reg <= '0;
                ST_OBJ_DRAW: spr_cnt_reg <= spr_cnt_reg + 8'd1;
                ST_OBJ_NEXT: if (!last_obj) obj_index_reg <= obj_index_reg + 3'd1;
                ST_FLUSH:    flush_cnt_reg <= (flush_cnt_reg == FLUSH_LAST) ?
                                              '0 : flush_cnt_reg + FW'(1);
                default: ;
            endcase

            load_x_reg          <= (state_next == ST_OBJ_LOAD);
            load_y_reg          <= (state_next == ST_OBJ_LOAD);
            enable_reg          <= (state_next == ST_OBJ_DRAW);
            draw_background_reg <= (state_next == ST_BG);
            resetn_c_reg        <= !((state_next == ST_IDLE) ||
                                     (state_next == ST_OBJ_LOAD) ||
                                     (state_next == ST_DONE));
            busy_reg            <= !((state_next == ST_IDLE) || (state_next == ST_DONE));
            done_reg            <= (state_next == ST_DONE);

            // Sprite type is captured while the object table is presenting
            // the current sprite and kept until the frame tail ends.
            if (state_reg == ST_OBJ_LOAD)
                load_stone_reg <= bus.obj_type;
            else if (!((state_next == ST_OBJ_DRAW) || (state_next == ST_OBJ_NEXT) ||
                       (state_next == ST_FLUSH)))
                load_stone_reg <= 1'b0;
        end
    end

    // Plot qualifier delay line matching the view datapath latency.
    genvar gi;
    generate
        for (gi = 0; gi < PIPE; gi++) begin : g_plot_pipe
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) plot_pipe_reg[gi] <= 1'b0;
                    else       plot_pipe_reg[gi] <= plot_qual;
                end
            end else begin : g_rest
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) plot_pipe_reg[gi] <= 1'b0;
                    else       plot_pipe_reg[gi] <= plot_pipe_reg[gi-1];
                end
            end
        end
    endgenerate

    assign bus.obj_index       = obj_index_reg;
    assign bus.load_x          = load_x_reg;
    assign bus.load_y          = load_y_reg;
    assign bus.load_stone      = load_stone_reg;
    assign bus.resetn_c        = resetn_c_reg;
    assign bus.enable_c        = enable_reg;
    assign bus.enable_x_adder  = enable_reg;
    assign bus.enable_y_adder  = enable_reg;
    assign bus.draw_background = draw_background_reg;
    assign bus.plot            = plot_pipe_reg[PIPE-1];
    assign bus.busy            = busy_reg;
    assign bus.done            = done_reg;
endmodule

// File: tb/tb_view_control.sv
// ---------------------------------------------------------------------------
// tb_view_control
// Directed frames against view_control: empty frame, oversubscribed frame
// with a start re-pulse, reset in the middle of a sprite pass, single stone
// sprite frame. A negedge monitor accumulates per-frame event counts.
// ---------------------------------------------------------------------------
module tb_view_control;
    localparam int PIPE     = 2;
    localparam int BG_CYC   = 131072;
    localparam int BG_PLOTS = 76800;
    localparam int LIMIT    = 140000;

    logic clk;
    logic reset;
    logic [1:0] type_sel;
    logic stat_clr;

    int tests_run    = 0;
    int tests_failed = 0;

    view_control_if bus();

    view_control #(.OBJ_MAX(8), .PIPE(PIPE), .SCR_W(320), .SCR_H(240)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Object table model: constant type, or stone on odd indices.
    always_comb begin
        bus.obj_type = (type_sel == 2'd2) ? bus.obj_index[0] : type_sel[0];
    end

    // Event monitor
    int cyc = 0;
    int m_bg, m_plot, m_ld, m_ld_err, m_en, m_stone, m_done, m_bg_last, m_done_cyc;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (stat_clr) begin
            m_bg <= 0; m_plot <= 0; m_ld <= 0; m_ld_err <= 0; m_en <= 0;
            m_stone <= 0; m_done <= 0; m_bg_last <= 0; m_done_cyc <= 0;
        end else begin
            if (bus.draw_background) begin
                m_bg      <= m_bg + 1;
                m_bg_last <= cyc;
            end
            if (bus.plot) m_plot <= m_plot + 1;
            if (bus.load_x) begin
                m_ld <= m_ld + 1;
                if (bus.obj_index != 3'(m_ld) || !bus.load_y || bus.resetn_c)
                    m_ld_err <= m_ld_err + 1;
            end
            if (bus.enable_c && bus.enable_x_adder && bus.enable_y_adder && bus.resetn_c) begin
                m_en <= m_en + 1;
                if (bus.load_stone) m_stone <= m_stone + 1;
            end
            if (bus.done) begin
                m_done     <= m_done + 1;
                m_done_cyc <= cyc;
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        stat_clr = 1'b1;
        repeat (2) @(posedge clk);
        stat_clr = 1'b0;
    endtask

    task automatic pulse_start(input logic [3:0] cnt);
        bus.obj_count = cnt;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_frame(input string name, input logic [3:0] cnt,
                             input logic [1:0] tsel, input bit repulse);
        int i;
        type_sel = tsel;
        clear_stats();
        pulse_start(cnt);
        check({name, "_busy_after_start"}, int'(bus.busy), 1);
        i = 0;
        while (m_done == 0 && i < LIMIT) begin
            @(posedge clk);
            i++;
            if (repulse && i == 1000) begin
                @(negedge clk);
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
        end
        check({name, "_timeout"}, int'(i >= LIMIT), 0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check({name, "_busy_after_done"}, int'(bus.busy), 0);
        $display("[TB] frame %s: bg=%0d plot=%0d loads=%0d en=%0d stone=%0d done=%0d",
                 name, m_bg, m_plot, m_ld, m_en, m_stone, m_done);
    endtask

    initial begin
        int i;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.obj_count = 4'd0;
        type_sel  = 2'd0;
        stat_clr  = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_resetn_c", int'(bus.resetn_c), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done_plot", int'(bus.done | bus.plot), 0);
        check("rst_obj_index", int'(bus.obj_index), 0);
        check("rst_draw_bg", int'(bus.draw_background), 0);
        reset = 1'b0;

        // Empty frame
        run_frame("empty", 4'd0, 2'd0, 1'b0);
        check("empty_bg_cycles", m_bg, BG_CYC);
        check("empty_plots", m_plot, BG_PLOTS);
        check("empty_loads", m_ld, 0);
        check("empty_enables", m_en, 0);
        check("empty_done", m_done, 1);
        check("empty_done_delay", m_done_cyc - m_bg_last, PIPE + 1);

        // 12 requested, clamped to 8; odd sprites are stone; start re-pulsed in BG
        run_frame("clamp", 4'd12, 2'd2, 1'b1);
        check("clamp_bg_cycles", m_bg, BG_CYC);
        check("clamp_loads", m_ld, 8);
        check("clamp_load_err", m_ld_err, 0);
        check("clamp_enables", m_en, 8 * 256);
        check("clamp_stone", m_stone, 4 * 256);
        check("clamp_plots", m_plot, BG_PLOTS + 8 * 256);
        check("clamp_done", m_done, 1);

        // Reset between edges during the second sprite's draw pass
        type_sel = 2'd0;
        clear_stats();
        pulse_start(4'd2);
        i = 0;
        while (!(bus.enable_c && bus.obj_index == 3'd1) && i < LIMIT) begin
            @(negedge clk);
            i++;
        end
        check("rst_mid_reach_draw", int'(i >= LIMIT), 0);
        repeat (50) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_enable", int'(bus.enable_c | bus.enable_x_adder | bus.enable_y_adder), 0);
        check("rst_mid_busy", int'(bus.busy), 0);
        check("rst_mid_resetn_c", int'(bus.resetn_c), 0);
        check("rst_mid_obj_index", int'(bus.obj_index), 0);
        check("rst_mid_plot", int'(bus.plot), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        check("rst_mid_no_done", m_done, 0);
        check("rst_mid_idle", int'(bus.busy | bus.draw_background), 0);
        $display("[TB] frame reset_mid: done=%0d", m_done);

        // Single stone sprite after reset
        run_frame("stone1", 4'd1, 2'd1, 1'b0);
        check("stone1_loads", m_ld, 1);
        check("stone1_load_err", m_ld_err, 0);
        check("stone1_enables", m_en, 256);
        check("stone1_stone", m_stone, 256);
        check("stone1_plots", m_plot, BG_PLOTS + 256);
        check("stone1_done", m_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
